pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Controller that owns and sequences the program counter for the single-issue core.
//   Issues instruction-fetch requests and holds each address until memory acknowledges.
//   Waits for the executing instruction to retire, then selects the next PC:
//   sequential, branch/jump target, or trap vector.
//   Sits between the execute stage, the instruction memory port and the PC consumers.
// PARAMETERS
//   WORDSIZE     64       width of PC, addresses and targets
//   RESET_ADDR   64'h0    PC value loaded on reset
//   TRAP_VECTOR  64'h100  PC loaded when a misaligned target is detected
//   STEP         4        sequential increment, in bytes
//   CNT_W        32       width of the retired-instruction counter
// PORTS
//   clk            in   1         single clock; all state updates on the rising edge
//   reset          in   1         synchronous, active-high; priority over all inputs
//   imem_req       out  1         fetch request to instruction memory
//   imem_addr      out  WORDSIZE  fetch address; equals pc
//   imem_ack       in   1         memory has accepted/returned the fetch for imem_addr
//   fetch_valid    out  1         1-cycle pulse: fetched instruction is ready for execute
//   retire         in   1         execute has finished the current instruction
//   branch_taken   in   1         with retire: redirect to branch_target
//   jalr           in   1         with branch_taken: clear bit 0 of branch_target
//   branch_target  in   WORDSIZE  redirect address
//   halt           in   1         with retire: stop sequencing
//   pc             out  WORDSIZE  current program counter (registered)
//   misaligned     out  1         sticky flag: a trap redirect occurred
//   instret        out  CNT_W     count of retired instructions
//   state          out  2         BOOT=00 FETCH=01 EXEC=10 HALTED=11
// BEHAVIOUR
//   Reset (sampled at clk edge)
//     pc=RESET_ADDR, state=BOOT, imem_req=0, fetch_valid=0, misaligned=0, instret=0.
//     Reset mid-fetch or mid-exec abandons the operation; no pending state survives.
//   BOOT
//     Stays one cycle, then goes to FETCH.
//     First imem_req=1 appears on the 2nd cycle after the reset-release edge.
//   FETCH
//     imem_req=1 (combinational from state); imem_addr=pc, held stable until ack.
//     On imem_ack=1: next edge -> EXEC and fetch_valid=1 for exactly that one cycle.
//     With no ack, remain in FETCH indefinitely.
//   EXEC
//     imem_req=0. Wait for retire=1. On a retire edge, instret increments (wraps mod 2^CNT_W).
//     Then the first matching case applies:
//       halt=1                     -> HALTED; pc unchanged.
//       next := branch_taken ? (jalr ? branch_target & ~1 : branch_target)
//                            : pc + STEP
//               (sum is modulo 2^WORDSIZE; pc at max wraps to STEP-4+0 region, e.g. 0 for STEP=4)
//       next[1:0] != 0             -> pc=TRAP_VECTOR, misaligned=1, -> FETCH.
//       otherwise                  -> pc=next, -> FETCH.
//   HALTED
//     All inputs ignored; pc and instret frozen; imem_req=0; exits only via reset.
//   Ignored inputs
//     imem_ack outside FETCH; retire/branch_taken/halt outside EXEC.
//     jalr is ignored when branch_taken=0.
//   Throughput
//     Minimum 2 cycles per instruction (ack in 1st FETCH cycle, retire in 1st EXEC cycle).
//   misaligned
//     Clears only on reset; multiple traps leave it set.
// TESTING
//   1. Reset 2 cycles, release, ack every FETCH, retire every EXEC
//      -> pc 0,4,8,C,10 in successive FETCHes; instret=4 at the 5th FETCH.
//   2. Hold imem_ack=0 for 5 cycles in FETCH
//      -> imem_req stays 1, imem_addr constant, no fetch_valid, state stays 01.
//   3. Retire at pc=8 with branch_taken=1, target=0x40
//      -> next FETCH addr 0x40; then jalr=1, target=0x81 -> addr 0x80.
//   4. Retire with branch_taken=1, target=0x42
//      -> pc=0x100, misaligned=1, and it stays 1 through later normal retires.
//   5. Retire with halt=1 at pc=0x10
//      -> state=11, pc=0x10, imem_req=0; further acks/retires have no effect;
//         reset -> pc=0, state=00.
//   6. Assert reset during EXEC at pc=0x20 and during FETCH with ack=1 same cycle
//      -> next cycle pc=0, state=BOOT, fetch_valid=0, instret=0.
//      Also: pc=2^64-4 sequential retire -> pc=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetches, waits for retire, then picks the next PC
// (sequential, branch/jump target, or trap vector on a misaligned target).
module pc_sequencer #(
   parameter int unsigned         WORDSIZE    = 64,
   parameter logic [WORDSIZE-1:0] RESET_ADDR  = '0,
   parameter logic [WORDSIZE-1:0] TRAP_VECTOR = WORDSIZE'('h100),
   parameter int unsigned         STEP        = 4,
   parameter int unsigned         CNT_W       = 32
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [WORDSIZE-1:0] imem_addr,
   input  logic                imem_ack,
   output logic                fetch_valid,
   input  logic                retire,
   input  logic                branch_taken,
   input  logic                jalr,
   input  logic [WORDSIZE-1:0] branch_target,
   input  logic                halt,
   output logic [WORDSIZE-1:0] pc,
   output logic                misaligned,
   output logic [CNT_W-1:0]    instret,
   output logic [1:0]          state
);

   localparam logic [WORDSIZE-1:0] StepW = WORDSIZE'(STEP);

   typedef enum logic [1:0] {
      StBoot   = 2'b00,
      StFetch  = 2'b01,
      StExec   = 2'b10,
      StHalted = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [WORDSIZE-1:0] pc_q, pc_d;
   logic [WORDSIZE-1:0] redirect, next_pc;
   logic                mis_q, mis_d;
   logic                fv_q, fv_d;
   logic [CNT_W-1:0]    instret_q, instret_d;

   always_comb begin
      redirect = jalr ? {branch_target[WORDSIZE-1:1], 1'b0} : branch_target;
      next_pc  = branch_taken ? redirect : pc_q + StepW;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      mis_d     = mis_q;
      fv_d      = 1'b0;
      instret_d = instret_q;
      case (state_q)
         StBoot: state_d = StFetch;
         StFetch: begin
            if (imem_ack) begin
               state_d = StExec;
               fv_d    = 1'b1;
            end
         end
         StExec: begin
            if (retire) begin
               instret_d = instret_q + CNT_W'(1);
               if (halt) begin
                  state_d = StHalted;
               end else begin
                  state_d = StFetch;
                  // A target that is not word aligned diverts to the trap vector
                  if (next_pc[1:0] != 2'b00) begin
                     pc_d  = TRAP_VECTOR;
                     mis_d = 1'b1;
                  end else begin
                     pc_d = next_pc;
                  end
               end
            end
         end
         StHalted: state_d = StHalted;
         default:  state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StBoot;
         pc_q      <= RESET_ADDR;
         mis_q     <= 1'b0;
         fv_q      <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         mis_q     <= mis_d;
         fv_q      <= fv_d;
         instret_q <= instret_d;
      end
   end

   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign fetch_valid = fv_q;
   assign misaligned  = mis_q;
   assign instret     = instret_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

   localparam logic [1:0] BOOT = 2'b00, FETCH = 2'b01, EXEC = 2'b10, HALTED = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_ack = 1'b0, retire = 1'b0, branch_taken = 1'b0, jalr = 1'b0, halt = 1'b0;
   logic [63:0] branch_target = '0;
   logic        imem_req, fetch_valid, misaligned;
   logic [63:0] imem_addr, pc;
   logic [31:0] instret;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .fetch_valid   (fetch_valid),
      .retire        (retire),
      .branch_taken  (branch_taken),
      .jalr          (jalr),
      .branch_target (branch_target),
      .halt          (halt),
      .pc            (pc),
      .misaligned    (misaligned),
      .instret       (instret),
      .state         (state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: phase of the instruction life-cycle and architectural counters
   logic [1:0]  m_phase;
   logic [63:0] m_pc;
   logic [31:0] m_cnt;
   logic        m_mis, m_fv;
   bit          m_known = 0;

   always @(posedge clk) begin
      logic [63:0] tgt;
      if (reset) begin
         m_phase = BOOT; m_pc = 64'h0; m_cnt = 0; m_mis = 0; m_fv = 0; m_known = 1;
      end else if (m_known) begin
         m_fv = 0;
         if (m_phase == BOOT) begin
            m_phase = FETCH;
         end else if (m_phase == FETCH && imem_ack) begin
            m_phase = EXEC; m_fv = 1;
         end else if (m_phase == EXEC && retire) begin
            m_cnt = m_cnt + 1;
            if (halt) begin
               m_phase = HALTED;
            end else begin
               if (branch_taken) tgt = jalr ? (branch_target - (branch_target % 2)) : branch_target;
               else              tgt = m_pc + 64'd4;
               if (tgt % 4 != 0) begin
                  m_pc = 64'h100; m_mis = 1;
               end else begin
                  m_pc = tgt;
               end
               m_phase = FETCH;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_known) begin
         chk("state", {62'b0, state}, {62'b0, m_phase});
         chk("pc", pc, m_pc);
         chk("imem_addr", imem_addr, m_pc);
         chk("imem_req", {63'b0, imem_req}, {63'b0, m_phase == FETCH});
         chk("fetch_valid", {63'b0, fetch_valid}, {63'b0, m_fv});
         chk("misaligned", {63'b0, misaligned}, {63'b0, m_mis});
         chk("instret", {32'b0, instret}, {32'b0, m_cnt});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for(input logic [1:0] st, input bit use_pc, input logic [63:0] p,
                           input string name);
      int n = 0;
      while (!(state == st && (!use_pc || pc == p)) && n < 100) begin
         cyc();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual_state=%0d required_state=%0d", name, state, st);
      end
   endtask

   task automatic set_in(input logic a, input logic r, input logic b, input logic j,
                         input logic h, input logic [63:0] t);
      imem_ack = a; retire = r; branch_taken = b; jalr = j; halt = h; branch_target = t;
   endtask

   logic [63:0] exp_pcs [5];

   initial begin
      exp_pcs = '{64'h0, 64'h4, 64'h8, 64'hc, 64'h10};
      // 1: straight-line sequencing
      set_in(0, 0, 0, 0, 0, 0);
      reset = 1; cyc(); cyc();
      chk("reset_state", {62'b0, state}, 64'(BOOT));
      chk("reset_pc", pc, 64'h0);
      reset = 0;
      set_in(1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         wait_for(FETCH, 0, 0, "seq_fetch");
         chk("seq_pc", pc, exp_pcs[k]);
         if (k == 4) chk("seq_instret", {32'b0, instret}, 64'd4);
         else cyc();
      end
      // 2: stall without ack
      set_in(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("stall_req", {63'b0, imem_req}, 64'd1);
         chk("stall_addr", imem_addr, 64'h10);
         chk("stall_fv", {63'b0, fetch_valid}, 64'd0);
      end
      set_in(1, 0, 0, 0, 0, 0); cyc();
      chk("ack_fv", {63'b0, fetch_valid}, 64'd1);
      // 3: branch and jalr
      set_in(0, 1, 1, 0, 0, 64'h40); cyc();
      chk("branch_addr", imem_addr, 64'h40);
      set_in(1, 0, 0, 0, 0, 0); cyc();
      set_in(0, 1, 1, 1, 0, 64'h81); cyc();
      chk("jalr_addr", imem_addr, 64'h80);
      chk("jalr_mis", {63'b0, misaligned}, 64'd0);
      // 4: misaligned target traps, flag stays sticky
      set_in(1, 0, 0, 0, 0, 0); cyc();
      set_in(0, 1, 1, 0, 0, 64'h42); cyc();
      chk("trap_pc", pc, 64'h100);
      chk("trap_mis", {63'b0, misaligned}, 64'd1);
      set_in(1, 1, 0, 0, 0, 0);
      repeat (4) cyc();
      chk("sticky_pc", pc, 64'h108);
      chk("sticky_mis", {63'b0, misaligned}, 64'd1);
      // 6b: sequential wrap at the top of the address space
      set_in(1, 0, 0, 0, 0, 0); cyc();
      set_in(0, 1, 1, 0, 0, 64'hffff_ffff_ffff_fffc); cyc();
      chk("top_pc", pc, 64'hffff_ffff_ffff_fffc);
      set_in(1, 0, 0, 0, 0, 0); cyc();
      set_in(0, 1, 0, 0, 0, 0); cyc();
      chk("wrap_pc", pc, 64'h0);
      // 5: halt freezes everything until reset
      set_in(1, 1, 0, 0, 0, 0);
      repeat (8) cyc();
      chk("pre_halt_pc", pc, 64'h10);
      set_in(1, 0, 0, 0, 0, 0); cyc();
      set_in(0, 1, 0, 0, 1, 0); cyc();
      chk("halt_state", {62'b0, state}, 64'(HALTED));
      chk("halt_instret", {32'b0, instret}, 64'd16);
      set_in(1, 1, 1, 0, 0, 64'h200);
      repeat (4) cyc();
      chk("halted_pc", pc, 64'h10);
      chk("halted_req", {63'b0, imem_req}, 64'd0);
      chk("halted_instret", {32'b0, instret}, 64'd16);
      reset = 1; cyc();
      chk("halt_reset_pc", pc, 64'h0);
      chk("halt_reset_state", {62'b0, state}, 64'(BOOT));
      // 6: reset during EXEC and during FETCH with ack
      reset = 0;
      set_in(1, 1, 0, 0, 0, 0);
      wait_for(EXEC, 1, 64'h20, "reach_exec_20");
      reset = 1; cyc();
      chk("rst_exec_pc", pc, 64'h0);
      chk("rst_exec_state", {62'b0, state}, 64'(BOOT));
      chk("rst_exec_instret", {32'b0, instret}, 64'd0);
      reset = 0;
      wait_for(FETCH, 0, 0, "reach_fetch");
      reset = 1; cyc();
      chk("rst_fetch_state", {62'b0, state}, 64'(BOOT));
      chk("rst_fetch_fv", {63'b0, fetch_valid}, 64'd0);
      reset = 0;
      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [63:0] t;
         t = {$urandom, $urandom};
         if ($urandom_range(3) != 0) t[1:0] = 2'b00;
         else if ($urandom_range(1) == 0) t[1:0] = 2'b01;
         set_in(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(9) < 3),
                1'($urandom_range(1)), ($urandom_range(49) == 0), t);
         reset = ($urandom_range(199) == 0) || (state == HALTED && $urandom_range(9) == 0);
         cyc();
      end
      reset = 0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
